sprite_draw_engine: RTL and testbench

- Drawing datapath directly downstream of the game controller.
- Takes one draw command per game state (erase/draw bird, erase/draw wall) with the object's position, and rasterises the object's bounding box one pixel per clock.
- Its pixel outputs (x, y, colour, plot) drive the 160x120 VGA adapter.
- A one-cycle done pulse tells the controller to advance to its next state.

---
 rtl/draw_pkg.sv | 32 +++
 rtl/box_sweeper.sv | 52 +++++
 rtl/sprite_draw_engine.sv | 150 +++++++++++++++
 tb/tb_sprite_draw_engine.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared constants for the sprite draw datapath: screen geometry, object sizes,
// command encodings and palette.
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BIRD_X   = 40;
  localparam int BIRD_W   = 4;
  localparam int BIRD_H   = 4;
  localparam int WALL_W   = 8;
  localparam int GAP_H    = 30;

  // Counter widths cover the largest box (8 columns, 120 rows).
  localparam int CX_W = 4;
  localparam int CY_W = 7;

  typedef enum logic [1:0] {
    OP_ERASE_BIRD = 2'b00,
    OP_DRAW_BIRD  = 2'b01,
    OP_ERASE_WALL = 2'b10,
    OP_DRAW_WALL  = 2'b11
  } op_e;

  localparam logic [2:0] BG_COLOUR   = 3'b000;
  localparam logic [2:0] BIRD_COLOUR = 3'b110;
  localparam logic [2:0] WALL_COLOUR = 3'b010;

  function automatic logic is_wall_op(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/box_sweeper.sv
// Row-major column/row walker over a w x h box; start clears, en advances.
// last flags the final (w-1, h-1) position combinationally.
module box_sweeper
  import draw_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            start_i,
  input  logic            en_i,
  input  logic [CX_W-1:0] w_i,
  input  logic [CY_W-1:0] h_i,
  output logic [CX_W-1:0] cx_o,
  output logic [CY_W-1:0] cy_o,
  output logic            last_o
);

  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;
  logic            row_end;

  assign row_end = (cx_q == w_i - CX_W'(1));
  assign last_o  = row_end && (cy_q == h_i - CY_W'(1));
  assign cx_o    = cx_q;
  assign cy_o    = cy_q;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (start_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en_i) begin
      if (row_end) begin
        cx_d = '0;
        cy_d = cy_q + CY_W'(1);
      end else begin
        cx_d = cx_q + CX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/sprite_draw_engine.sv
// Rasterises one bird/wall bounding box per command, one registered pixel per clock,
// with clipping and wall-gap suppression; pulses done once the box is finished.
module sprite_draw_engine
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [6:0] bird_y,
  input  logic [7:0] wall_x,
  input  logic [6:0] gap_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0] state_q, state_d;
  op_e        op_q;
  logic [6:0] bird_y_q;
  logic [7:0] wall_x_q;
  logic [6:0] gap_y_q;

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;

  logic            accept;
  logic            sweeping;
  logic            wall_op;
  logic [7:0]      org_x;
  logic [6:0]      org_y;
  logic [CX_W-1:0] box_w;
  logic [CY_W-1:0] box_h;
  logic [CX_W-1:0] cx;
  logic [CY_W-1:0] cy;
  logic            last;
  logic [8:0]      x_wide;
  logic [7:0]      y_wide;
  logic [7:0]      gap_lo;
  logic [7:0]      gap_hi;
  logic            clipped;
  logic            in_gap;

  assign accept   = cmd_valid && ready_q;
  assign sweeping = (state_q == S_SWEEP);
  assign wall_op  = is_wall_op(op_q);

  assign org_x = wall_op ? wall_x_q : 8'(BIRD_X);
  assign org_y = wall_op ? 7'd0 : bird_y_q;
  assign box_w = wall_op ? CX_W'(WALL_W) : CX_W'(BIRD_W);
  assign box_h = wall_op ? CY_W'(SCREEN_H) : CY_W'(BIRD_H);

  box_sweeper u_sweeper (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (accept),
    .en_i    (sweeping),
    .w_i     (box_w),
    .h_i     (box_h),
    .cx_o    (cx),
    .cy_o    (cy),
    .last_o  (last)
  );

  // One extra bit so off-screen coordinates compare correctly before truncation.
  assign x_wide  = {1'b0, org_x} + 9'(cx);
  assign y_wide  = {1'b0, org_y} + 8'(cy);
  assign clipped = (x_wide >= 9'(SCREEN_W)) || (y_wide >= 8'(SCREEN_H));
  assign gap_lo  = {1'b0, gap_y_q};
  assign gap_hi  = gap_lo + 8'(GAP_H);
  assign in_gap  = (op_q == OP_DRAW_WALL) && (y_wide >= gap_lo) && (y_wide < gap_hi);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SWEEP;
      S_SWEEP: if (last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (sweeping) begin
      x_d = x_wide[7:0];
      y_d = y_wide[6:0];
      case (op_q)
        OP_DRAW_BIRD: colour_d = BIRD_COLOUR;
        OP_DRAW_WALL: colour_d = WALL_COLOUR;
        default:      colour_d = BG_COLOUR;
      endcase
    end
    plot_d  = sweeping && !clipped && !in_gap;
    done_d  = (state_q == S_DONE);
    // Ready drops on acceptance and only returns one cycle after the done pulse.
    ready_d = (state_q == S_IDLE) && !accept;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ERASE_BIRD;
      bird_y_q <= '0;
      wall_x_q <= '0;
      gap_y_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      if (accept) begin
        op_q     <= op_e'(cmd_op);
        bird_y_q <= bird_y;
        wall_x_q <= wall_x;
        gap_y_q  <= gap_y;
      end
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Scoreboarded bench: stimulus pushes expected plotted pixels, a negedge monitor
// pops and compares on every plot and tracks accept/done timing.
module tb_sprite_draw_engine;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [6:0] bird_y;
  logic [7:0] wall_x;
  logic [6:0] gap_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;

  sprite_draw_engine dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .bird_y    (bird_y),
    .wall_x    (wall_x),
    .gap_y     (gap_y),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int plot_cnt = 0;
  int last_acc = 0;
  int last_done = 0;
  logic [17:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: inputs change just after posedge, outputs are stable at negedge.
  always @(negedge clk) begin
    logic [17:0] e;
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      acc_cnt++;
      last_acc = cyc + 1;
    end
    if (done === 1'b1) begin
      done_cnt++;
      last_done = cyc;
      chk("plot_in_done", {31'd0, plot}, 32'd0);
      chk("ready_in_done", {31'd0, cmd_ready}, 32'd0);
    end
    if (plot === 1'b1) begin
      plot_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_plot: got x=%0d y=%0d c=%b, expected no plot", x, y, colour);
      end else begin
        e = exp_q.pop_front();
        if ({x, y, colour} !== e) begin
          n_fail++;
          $display("FAIL pixel: got x=%0d y=%0d c=%b, expected x=%0d y=%0d c=%b",
                   x, y, colour, e[17:10], e[9:3], e[2:0]);
        end
      end
    end
  end

  task automatic build_exp(input logic [1:0] op, input int by, input int wx, input int gy);
    int ox, oy, w, h, xw, yw;
    logic [2:0] col;
    logic [7:0] xv;
    logic [6:0] yv;
    if (op[1]) begin ox = wx; oy = 0;  w = 8; h = 120; end
    else       begin ox = 40; oy = by; w = 4; h = 4;   end
    col = (op == 2'b01) ? 3'b110 : (op == 2'b11) ? 3'b010 : 3'b000;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        xw = ox + c;
        yw = oy + r;
        if (xw >= 160 || yw >= 120) continue;
        if (op == 2'b11 && yw >= gy && yw < gy + 30) continue;
        xv = xw[7:0];
        yv = yw[6:0];
        exp_q.push_back({xv, yv, col});
      end
    end
  endtask

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (cmd_ready === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: got cmd_ready=0, expected 1 within 2000 cycles");
    end
  endtask

  task automatic drive(input logic [1:0] op, input int by, input int wx, input int gy);
    cmd_op = op;
    bird_y = by[6:0];
    wall_x = wx[7:0];
    gap_y  = gy[6:0];
  endtask

  task automatic send(input logic [1:0] op, input int by, input int wx, input int gy);
    build_exp(op, by, wx, gy);
    wait_ready();
    drive(op, by, wx, gy);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    drive(~op, by + 3, wx + 5, gy + 7);
  endtask

  task automatic wait_done(input int d0);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt > d0) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done, expected done within 3000 cycles");
    end
  endtask

  task automatic finish_cmd(input string name, input int d0, input int p0,
                            input int exp_plots, input int lat);
    wait_done(d0);
    chk({name, "_done_lat"}, last_done - last_acc, lat);
    chk({name, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
    chk({name, "_plots"}, plot_cnt - p0, exp_plots);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0, p0, a0;
    resetn = 1'b1;
    cmd_valid = 1'b0;
    drive(2'b00, 0, 0, 0);
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", {24'd0, x}, 32'd0);
    chk("rst_y", {25'd0, y}, 32'd0);
    chk("rst_colour", {29'd0, colour}, 32'd0);
    chk("rst_plot", {31'd0, plot}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    d0 = done_cnt; p0 = plot_cnt;
    send(2'b01, 10, 0, 0);
    finish_cmd("bird10", d0, p0, 16, 17);

    d0 = done_cnt; p0 = plot_cnt;
    send(2'b11, 0, 100, 50);
    finish_cmd("wall100", d0, p0, 720, 961);

    d0 = done_cnt; p0 = plot_cnt;
    send(2'b10, 0, 156, 0);
    finish_cmd("erase156", d0, p0, 480, 961);

    d0 = done_cnt; p0 = plot_cnt;
    send(2'b01, 118, 0, 0);
    finish_cmd("bird118", d0, p0, 8, 17);

    d0 = done_cnt; p0 = plot_cnt;
    send(2'b11, 0, 20, 100);
    finish_cmd("gap100", d0, p0, 800, 961);

    // Valid pulse while sweeping must be dropped, not queued.
    d0 = done_cnt; p0 = plot_cnt; a0 = acc_cnt;
    send(2'b01, 20, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    drive(2'b11, 5, 30, 5);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    finish_cmd("midpulse", d0, p0, 16, 17);
    repeat (30) @(posedge clk);
    #1;
    chk("midpulse_acc", acc_cnt - a0, 1);
    chk("midpulse_dones", done_cnt - d0, 1);

    // Back-to-back: valid held high; operand changes mid-sweep must be ignored.
    d0 = done_cnt; p0 = plot_cnt; a0 = acc_cnt;
    build_exp(2'b01, 30, 0, 0);
    build_exp(2'b00, 70, 0, 0);
    wait_ready();
    drive(2'b01, 30, 0, 0);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    drive(2'b00, 70, 0, 0);
    wait_done(d0);
    chk("b2b_first_lat", last_done - last_acc, 17);
    chk("b2b_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b_acc", acc_cnt - a0, 2);
    chk("b2b_accept_gap", last_acc - last_done, 2);
    wait_done(d0 + 1);
    chk("b2b_second_lat", last_done - last_acc, 17);
    chk("b2b_plots", plot_cnt - p0, 32);
    chk("b2b_queue_empty", exp_q.size(), 0);

    // Reset mid-sweep: aborts immediately, no done afterwards.
    send(2'b11, 0, 60, 40);
    repeat (300) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("abort_plot", {31'd0, plot}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
    chk("abort_x", {24'd0, x}, 32'd0);
    exp_q.delete();
    d0 = done_cnt; p0 = plot_cnt;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_first_clk", {31'd0, cmd_ready}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_plot", plot_cnt - p0, 0);

    send(2'b01, 60, 0, 0);
    finish_cmd("bird_after_rst", d0, p0, 16, 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
